// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and sequencer sharing one 1024x4 dual-address RAM between port A and port B.
// Optional lock/burst ownership is compiled in when RAM_ARB_LOCK_EN is defined.
module ram_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic              lock_a,
    input  logic              lock_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_dout
);
    // Handshake: a beat transfers on a rising clk edge where req_x && gnt_x. req_x and its fields are
    // held by the requester until then; gnt_x is combinational and never asserted for both ports.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic              last_q;
    logic              rr_a;
    logic              rr_b;
    logic              gnt_a_c;
    logic              gnt_b_c;
    logic              acc_a;
    logic              acc_b;
    logic              acc_any;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] din_q;
    logic [ADDR_W-1:0] raddr_q;
    logic              pend_a_q;
    logic              pend_b_q;
    logic              rvalid_a_q;
    logic              rvalid_b_q;

    assign rr_a = req_a && (!req_b || last_q == PORT_B);
    assign rr_b = req_b && !rr_a;

`ifdef RAM_ARB_LOCK_EN
    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} own_t;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    own_t             own_q;
    own_t             own_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             acc_lock;

    always_comb begin
        gnt_a_c = 1'b0;
        gnt_b_c = 1'b0;
        if (rst_n) begin
            case (own_q)
                OWN_A:   gnt_a_c = req_a;
                OWN_B:   gnt_b_c = req_b;
                default: begin
                    gnt_a_c = rr_a;
                    gnt_b_c = rr_b;
                end
            endcase
        end
    end

    assign acc_lock = acc_a ? lock_a : lock_b;

    // cnt_q counts beats of the current tenure; an idle owner keeps ownership.
    always_comb begin
        own_d = own_q;
        cnt_d = cnt_q;
        if (acc_any) begin
            if (acc_lock && (int'(cnt_q) + 1 < MAX_BURST)) begin
                own_d = acc_b ? OWN_B : OWN_A;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                own_d = OWN_NONE;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_q <= OWN_NONE;
            cnt_q <= '0;
        end else begin
            own_q <= own_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_lock;

    assign gnt_a_c     = rst_n && rr_a;
    assign gnt_b_c     = rst_n && rr_b;
    assign unused_lock = lock_a ^ lock_b ^ (MAX_BURST > 0);
`endif

    assign acc_a     = req_a && gnt_a_c;
    assign acc_b     = req_b && gnt_b_c;
    assign acc_any   = acc_a || acc_b;
    assign acc_we    = acc_a ? we_a : we_b;
    assign acc_addr  = acc_a ? addr_a : addr_b;
    assign acc_wdata = acc_a ? wdata_a : wdata_b;

    // Read issuer travels two stages so rvalid lines up with the RAM's registered dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= PORT_B;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            din_q      <= '0;
            raddr_q    <= '0;
            pend_a_q   <= 1'b0;
            pend_b_q   <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            wen_q      <= acc_any && acc_we;
            pend_a_q   <= acc_a && !we_a;
            pend_b_q   <= acc_b && !we_b;
            rvalid_a_q <= pend_a_q;
            rvalid_b_q <= pend_b_q;
            if (acc_any) begin
                last_q <= acc_b ? PORT_B : PORT_A;
                if (acc_we) begin
                    waddr_q <= acc_addr;
                    din_q   <= acc_wdata;
                end else begin
                    raddr_q <= acc_addr;
                end
            end
        end
    end

    assign gnt_a        = gnt_a_c;
    assign gnt_b        = gnt_b_c;
    assign rvalid_a     = rvalid_a_q;
    assign rvalid_b     = rvalid_b_q;
    assign rdata        = ram_dout;
    assign ram_write_en = wen_q;
    assign ram_waddr    = waddr_q;
    assign ram_din      = din_q;
    assign ram_raddr    = raddr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: bench for ram_arbiter with a behavioural 1024x4 RAM (registered read) attached.
// Lock expectations follow the RAM_ARB_LOCK_EN macro.
module tb_ram_arbiter;
  logic       clk;
  logic       rst_n;
  logic       req_a, req_b, we_a, we_b, lock_a, lock_b;
  logic [9:0] addr_a, addr_b;
  logic [3:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [3:0] rdata;
  logic       ram_write_en;
  logic [9:0] ram_waddr, ram_raddr;
  logic [3:0] ram_din, ram_dout;
  logic       mem_clr;

  int errors = 0;
  int checks = 0;
  int rva_cnt = 0;
  int rvb_cnt = 0;

  logic [3:0] mem [0:1023];
  logic [3:0] ref_mem [0:1023];
  logic [3:0] exp_a_q[$];
  logic [3:0] exp_b_q[$];
  logic       log_q[$];   // accepted port per beat: 0 = A, 1 = B

  ram_arbiter #(.ADDR_W(10), .DATA_W(4), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .lock_a(lock_a), .lock_b(lock_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .rvalid_a(rvalid_a), .rvalid_b(rvalid_b), .rdata(rdata),
    .ram_write_en(ram_write_en), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RAM model: synchronous write, registered read (read-before-write on the same edge)
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 4'h0;
    end else begin
      if (ram_write_en) mem[ram_waddr] <= ram_din;
      ram_dout <= mem[ram_raddr];
    end
  end

  // scoreboard: record accepts, predict read data, check rvalid/rdata
  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 4'h0;
    end else if (rst_n) begin
      checks++;
      if (gnt_a && gnt_b) begin
        errors++;
        $display("FAIL gnt_exclusive: gnt_a=%b gnt_b=%b expected not both 1", gnt_a, gnt_b);
      end
      if (rvalid_a) begin
        rva_cnt++;
        checks++;
        if (exp_a_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_a_unexpected: rvalid_a=1 with no read pending");
        end else begin
          logic [3:0] e;
          e = exp_a_q.pop_front();
          if (rdata !== e) begin
            errors++;
            $display("FAIL rdata_a: got %h expected %h", rdata, e);
          end
        end
      end
      if (rvalid_b) begin
        rvb_cnt++;
        checks++;
        if (exp_b_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_b_unexpected: rvalid_b=1 with no read pending");
        end else begin
          logic [3:0] e;
          e = exp_b_q.pop_front();
          if (rdata !== e) begin
            errors++;
            $display("FAIL rdata_b: got %h expected %h", rdata, e);
          end
        end
      end
      if (req_a && gnt_a) begin
        log_q.push_back(1'b0);
        if (we_a) ref_mem[addr_a] = wdata_a;
        else exp_a_q.push_back(ref_mem[addr_a]);
      end
      if (req_b && gnt_b) begin
        log_q.push_back(1'b1);
        if (we_b) ref_mem[addr_b] = wdata_b;
        else exp_b_q.push_back(ref_mem[addr_b]);
      end
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the accepting edge
  task automatic drive_a(input logic we, input logic [9:0] addr, input logic [3:0] d, input logic lk);
    int n = 0;
    req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = d; lock_a = lk;
    do begin @(negedge clk); n++; end while (!gnt_a && n < 200);
    if (!gnt_a) begin
      checks++; errors++;
      $display("FAIL gnt_a_timeout: gnt_a=%b expected 1 within 200 cycles", gnt_a);
    end
    @(posedge clk); #1;
    req_a = 1'b0; lock_a = 1'b0;
  endtask

  task automatic drive_b(input logic we, input logic [9:0] addr, input logic [3:0] d, input logic lk);
    int n = 0;
    req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = d; lock_b = lk;
    do begin @(negedge clk); n++; end while (!gnt_b && n < 200);
    if (!gnt_b) begin
      checks++; errors++;
      $display("FAIL gnt_b_timeout: gnt_b=%b expected 1 within 200 cycles", gnt_b);
    end
    @(posedge clk); #1;
    req_b = 1'b0; lock_b = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
    repeat (3) @(posedge clk);
    mem_clr = 1'b0;
    exp_a_q.delete(); exp_b_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    drive_a(1'b1, 10'd5, 4'hA, 1'b0);
    checks++;
    if (ram_write_en !== 1'b1 || ram_waddr !== 10'd5 || ram_din !== 4'hA) begin
      errors++;
      $display("FAIL wr_bus: got we=%b waddr=%0d din=%h expected 1 5 a", ram_write_en, ram_waddr, ram_din);
    end
    drive_a(1'b0, 10'd5, 4'h0, 1'b0);
    checks++;
    if (ram_write_en !== 1'b0 || ram_raddr !== 10'd5 || rvalid_a !== 1'b0) begin
      errors++;
      $display("FAIL rd_issue: got we=%b raddr=%0d rvalid_a=%b expected 0 5 0", ram_write_en, ram_raddr, rvalid_a);
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid_a !== 1'b1 || rdata !== 4'hA) begin
      errors++;
      $display("FAIL rd_latency: got rvalid_a=%b rdata=%h expected 1 a", rvalid_a, rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (rvalid_a !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_pulse: got rvalid_a=%b expected 0", rvalid_a);
    end
  endtask

  task automatic test_alternate();
    int n = 0;
    int ra0, rb0;
    apply_reset();
    log_q.delete();
    ra0 = rva_cnt; rb0 = rvb_cnt;
    fork
      for (int i = 1; i <= 4; i++) drive_a(1'b1, 10'(i), 4'(i), 1'b0);
      for (int i = 0; i < 4; i++) drive_b(1'b0, 10'(100 + i), 4'h0, 1'b0);
    join
    while ((exp_b_q.size() != 0) && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (log_q.size() != 8) begin
      errors++;
      $display("FAIL alt_count: got %0d beats expected 8", log_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (log_q[i] !== 1'(i % 2)) begin
          errors++;
          $display("FAIL alt_order[%0d]: got port %0d expected %0d", i, log_q[i], i % 2);
        end
      end
    end
    checks++;
    if (rvb_cnt - rb0 != 4 || rva_cnt != ra0) begin
      errors++;
      $display("FAIL alt_rvalid: got b=%0d a=%0d expected 4 0", rvb_cnt - rb0, rva_cnt - ra0);
    end
  endtask

  task automatic test_raw();
    int n = 0;
    fork
      drive_a(1'b1, 10'd9, 4'h7, 1'b0);
      begin @(posedge clk); #1; drive_b(1'b0, 10'd9, 4'h0, 1'b0); end
    join
    while (!rvalid_b && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (rvalid_b !== 1'b1 || rdata !== 4'h7) begin
      errors++;
      $display("FAIL raw_new: got rvalid_b=%b rdata=%h expected 1 7", rvalid_b, rdata);
    end
    drive_a(1'b1, 10'd20, 4'h3, 1'b0);
    fork
      drive_b(1'b0, 10'd20, 4'h0, 1'b0);
      begin @(posedge clk); #1; drive_a(1'b1, 10'd20, 4'hC, 1'b0); end
    join
    n = 0;
    while (!rvalid_b && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (rvalid_b !== 1'b1 || rdata !== 4'h3) begin
      errors++;
      $display("FAIL raw_old: got rvalid_b=%b rdata=%h expected 1 3", rvalid_b, rdata);
    end
  endtask

  task automatic test_reset();
    int ra0;
    drive_a(1'b1, 10'd7, 4'h9, 1'b0);
    drive_a(1'b0, 10'd7, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    req_a = 1'b1; we_a = 1'b0; req_b = 1'b1; we_b = 1'b1;
    #1;
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || ram_write_en !== 1'b0 || ram_waddr !== 10'd0 ||
        ram_din !== 4'h0 || ram_raddr !== 10'd0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got gnt=%b%b we=%b waddr=%0d din=%h raddr=%0d rv=%b%b expected all 0",
               gnt_a, gnt_b, ram_write_en, ram_waddr, ram_din, ram_raddr, rvalid_a, rvalid_b);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || rvalid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got gnt=%b%b rvalid_a=%b expected 0 0 0", gnt_a, gnt_b, rvalid_a);
    end
    exp_a_q.delete(); exp_b_q.delete();
    req_a = 1'b0; req_b = 1'b0;
    ra0 = rva_cnt;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rva_cnt != ra0) begin
      errors++;
      $display("FAIL reset_discard: got %0d rvalid_a pulses expected 0", rva_cnt - ra0);
    end
  endtask

  task automatic test_lock();
    logic exp_log[$];
    // 20 locked beats from A (last one unlocked) against 6 beats from B
    apply_reset();
    log_q.delete();
    fork
      for (int i = 0; i < 20; i++) drive_a(1'b1, 10'(200 + i), 4'(i), (i != 19));
      for (int i = 0; i < 6; i++) drive_b(1'b1, 10'(300 + i), 4'(i), 1'b0);
    join
`ifdef RAM_ARB_LOCK_EN
    for (int i = 0; i < 16; i++) exp_log.push_back(1'b0);
    exp_log.push_back(1'b1);
    for (int i = 0; i < 4; i++) exp_log.push_back(1'b0);
    for (int i = 0; i < 5; i++) exp_log.push_back(1'b1);
`else
    for (int i = 0; i < 6; i++) begin exp_log.push_back(1'b0); exp_log.push_back(1'b1); end
    for (int i = 0; i < 14; i++) exp_log.push_back(1'b0);
`endif
    // A locks beats 1-2, releases on beat 3, against 2 beats from B
    apply_reset();
    fork
      for (int i = 0; i < 3; i++) drive_a(1'b1, 10'(400 + i), 4'(i), (i != 2));
      for (int i = 0; i < 2; i++) drive_b(1'b1, 10'(500 + i), 4'(i), 1'b0);
    join
`ifdef RAM_ARB_LOCK_EN
    exp_log.push_back(1'b0); exp_log.push_back(1'b0); exp_log.push_back(1'b0);
    exp_log.push_back(1'b1); exp_log.push_back(1'b1);
`else
    exp_log.push_back(1'b0); exp_log.push_back(1'b1); exp_log.push_back(1'b0);
    exp_log.push_back(1'b1); exp_log.push_back(1'b0);
`endif
    checks++;
    if (log_q.size() != exp_log.size()) begin
      errors++;
      $display("FAIL lock_count: got %0d beats expected %0d", log_q.size(), exp_log.size());
    end else begin
      for (int i = 0; i < exp_log.size(); i++) begin
        checks++;
        if (log_q[i] !== exp_log[i]) begin
          errors++;
          $display("FAIL lock_order[%0d]: got port %0d expected %0d", i, log_q[i], exp_log[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int n = 0;
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        drive_a(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      end
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        drive_b(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      end
    join
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got pending a=%0d b=%0d expected 0 0", exp_a_q.size(), exp_b_q.size());
    end
  endtask

  initial begin
    mem_clr = 1'b1;
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    apply_reset();
    test_write_read();
    test_alternate();
    test_raw();
    test_reset();
    test_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
